// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_pkg
//  Purpose  : Shared constants and helpers for the N:1 round-robin channel mux
//  Revision : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Values of the mode input
    localparam logic MODE_SEL = 1'b0;   // explicit channel select
    localparam logic MODE_RR  = 1'b1;   // round-robin among valid channels

    // Ceiling log2, used to derive the channel-index width from NCH.
    // Returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_nto1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Round-robin arbiter. Searches the request vector starting at the
//             internal pointer and wrapping modulo NCH; owns the pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  i_req,
    input  logic            i_enable,     // grant outputs forced low when 0
    input  logic            i_update,     // a channel was served this cycle
    input  logic [SELW-1:0] i_upd_idx,    // index of the channel just served
    output logic [NCH-1:0]  o_grant,
    output logic [SELW-1:0] o_grant_idx
);

    logic [SELW-1:0] r_ptr;
    logic            w_found;
    logic [SELW-1:0] w_idx;

    // (base + off) mod NCH, with base < NCH and off <= NCH
    function automatic logic [SELW-1:0] f_wrap(input logic [SELW-1:0] base,
                                               input int off);
        int t;
        t = int'(base) + off;
        if (t >= NCH) begin
            t = t - NCH;
        end
        return t[SELW-1:0];
    endfunction

    // Priority search: first requester at or after the pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < NCH; off++) begin
            if (!w_found && i_req[f_wrap(r_ptr, off)]) begin
                w_found = 1'b1;
                w_idx   = f_wrap(r_ptr, off);
            end
        end
    end

    // One-hot grant only when the arbiter is the active selection source
    always_comb begin
        o_grant     = '0;
        o_grant_idx = w_idx;
        if (i_enable && w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    // Pointer moves to the channel after the one just served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= f_wrap(i_upd_idx, 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : mux_nto1_rr
//  Purpose  : N-channel W-bit flow-controlled multiplexer with a single
//             registered output stage. Channel chosen by explicit select or by
//             round-robin among valid channels.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_nto1_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2     // must equal clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    // Select indices can exceed NCH-1; pad the valid vector to cover them
    localparam int NSEL = 1 << SELW;

    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic [SELW-1:0]  r_out_ch;

    logic [NSEL-1:0]  w_valid_pad;
    logic [NSEL-1:0]  w_sel_grant_pad;
    logic [NCH-1:0]   w_sel_grant;
    logic [NCH-1:0]   w_rr_grant;
    logic [SELW-1:0]  w_rr_idx;
    logic [NCH-1:0]   w_grant;
    logic [SELW-1:0]  w_idx;
    logic             w_load_en;
    logic             w_xfer;
    logic             w_rr_mode;
    logic [WIDTH-1:0] w_data;

    assign w_rr_mode = (mode == MODE_RR);

    // The output register can take a new word when empty or being drained
    assign w_load_en = !r_out_valid || out_ready;

    // Select-mode decode; out-of-range selects land on padded zero bits
    always_comb begin
        w_valid_pad            = '0;
        w_valid_pad[NCH-1:0]   = in_valid;
        w_sel_grant_pad        = '0;
        w_sel_grant_pad[sel]   = w_valid_pad[sel];
        w_sel_grant            = w_sel_grant_pad[NCH-1:0];
    end

    rr_arbiter #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .i_req       (in_valid),
        .i_enable    (w_rr_mode),
        .i_update    (w_rr_mode && w_xfer),
        .i_upd_idx   (w_idx),
        .o_grant     (w_rr_grant),
        .o_grant_idx (w_rr_idx)
    );

    // Choose the active grant source
    always_comb begin
        w_grant = w_sel_grant;
        w_idx   = sel;
        if (w_rr_mode) begin
            w_grant = w_rr_grant;
            w_idx   = w_rr_idx;
        end
    end

    // Ready only to the granted channel, and only when the output can load
    assign in_ready = w_grant & {NCH{w_load_en}};
    assign w_xfer   = |in_ready;

    // One-hot data selection from the granted channel
    always_comb begin
        w_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_grant[k]) begin
                w_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: load on input transfer, empty on drain without refill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_xfer) begin
            r_out       <= w_data;
            r_out_valid <= 1'b1;
            r_out_ch    <= w_idx;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_nto1_rr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_nto1_rr
//  Purpose  : Self-checking bench for mux_nto1_rr (NCH=4 main instance and an
//             NCH=3 instance for out-of-range select)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // NCH=4 instance
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    // NCH=3 instance
    logic        mode3;
    logic [1:0]  sel3;
    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic [7:0]  out3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_ptr;
    logic [7:0]  m_out;
    logic        m_vld;
    int          m_ch;

    always #5 clk = ~clk;

    mux_nto1_rr #(.WIDTH(8), .NCH(4), .SELW(2)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_nto1_rr #(.WIDTH(8), .NCH(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_data(in_data3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out(out3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Which channel the rules grant now, or -1 for none
    function automatic int model_grant(input logic md, input logic [1:0] s,
                                       input logic [3:0] v);
        if (md == 1'b0) begin
            if (int'(s) < 4 && v[s]) return int'(s);
            return -1;
        end
        for (int i = 0; i < 4; i++) begin
            if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0;
        m_out = 8'h00;
        m_vld = 1'b0;
        m_ch  = 0;
    endtask

    // One clock cycle: drive inputs, check ready, clock, check outputs.
    // Entered and left at posedge + 1.
    task automatic step(input logic md, input logic [1:0] s, input logic [3:0] v,
                        input logic [31:0] d, input logic ordy);
        int         g;
        logic       load;
        logic [3:0] exp_rdy;
        mode      = md;
        sel       = s;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        g       = model_grant(md, s, v);
        load    = !m_vld || ordy;
        exp_rdy = (g >= 0 && load) ? 4'(1 << g) : 4'b0000;
        check_eq("in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
        @(posedge clk);
        if (g >= 0 && load) begin
            m_out = d[g*8 +: 8];
            m_ch  = g;
            m_vld = 1'b1;
            if (md) m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_vld = 1'b0;
        end
        #1;
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, m_vld});
        check_eq("out", {24'b0, out}, {24'b0, m_out});
        check_eq("out_ch", {30'b0, out_ch}, 32'(m_ch));
    endtask

    logic [7:0] rr_exp_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
    int         rr_exp_ch   [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        mode = 0; sel = 0; in_data = 0; in_valid = 0; out_ready = 0;
        mode3 = 0; sel3 = 0; in_data3 = 0; in_valid3 = 0; out_ready3 = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out", {24'b0, out}, 32'h00);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_out_ch", {30'b0, out_ch}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle: nothing requested, nothing ready
        step(1'b0, 2'd0, 4'b0000, 32'h0, 1'b1);
        check_eq("idle_ready", {28'b0, in_ready}, 32'h0);

        // Select mode, channel 2
        step(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1);
        check_eq("sel_out", {24'b0, out}, 32'hA5);
        check_eq("sel_ch", {30'b0, out_ch}, 32'd2);
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; out_ready = 1'b1;
        #1;
        check_eq("sel_unsel_ready1", {31'b0, in_ready[1]}, 32'h0);
        step(1'b0, 2'd2, 4'b0110, 32'h00A5_2200, 1'b1);

        // Round-robin fairness, all channels valid
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd0, 4'b1111, 32'h1312_1110, 1'b1);
            check_eq("rr_ch", {30'b0, out_ch}, 32'(rr_exp_ch[i]));
            check_eq("rr_out", {24'b0, out}, {24'b0, rr_exp_data[i]});
        end

        // Backpressure
        step(1'b1, 2'd0, 4'b0010, 32'h0000_3300, 1'b1);
        check_eq("bp_load", {24'b0, out}, 32'h33);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'd0, 4'b1000, 32'h7700_0000, 1'b0);
            check_eq("bp_hold_out", {24'b0, out}, 32'h33);
            check_eq("bp_hold_ready", {28'b0, in_ready}, 32'h0);
            check_eq("bp_ptr", {30'b0, dut.u_arb.r_ptr}, 32'd2);
        end
        mode = 1'b1; in_valid = 4'b1000; in_data = 32'h7700_0000; out_ready = 1'b1;
        #1;
        check_eq("bp_release_ready", {28'b0, in_ready}, 32'h8);
        step(1'b1, 2'd0, 4'b1000, 32'h7700_0000, 1'b1);
        check_eq("bp_release_out", {24'b0, out}, 32'h77);

        // Out-of-range select on the NCH=3 instance
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; in_data3 = 24'h332211;
        out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("sel3_ready", {29'b0, in_ready3}, 32'h0);
            @(posedge clk);
            #1;
            check_eq("sel3_out_valid", {31'b0, out_valid3}, 32'h0);
        end
        sel3 = 2'd2;
        @(posedge clk);
        #1;
        check_eq("sel3_in_range", {23'b0, out_valid3, out3}, 32'h133);
        in_valid3 = 3'b000;

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset with a word held and ptr = 3
        step(1'b1, 2'd0, 4'b0100, 32'h00C3_0000, 1'b1);
        check_eq("pre_rst_ptr", {30'b0, dut.u_arb.r_ptr}, 32'd3);
        check_eq("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out", {24'b0, out}, 32'h00);
        check_eq("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check_eq("arst_out_ch", {30'b0, out_ch}, 32'h0);
        check_eq("arst_ptr", {30'b0, dut.u_arb.r_ptr}, 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 2'd0, 4'b0101, 32'h00BB_00AA, 1'b1);
        check_eq("post_rst_first_ch", {30'b0, out_ch}, 32'd0);
        check_eq("post_rst_first_out", {24'b0, out}, 32'hAA);
        step(1'b1, 2'd0, 4'b0101, 32'h00BB_00AA, 1'b1);
        check_eq("post_rst_second_ch", {30'b0, out_ch}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_nto1_rr.md
# mux_nto1_rr

Parametrised N-channel, W-bit multiplexer with a registered output, valid/ready handshakes on every input and on the output, and two selection modes: explicit select, or round-robin among valid channels. It generalises the single-bit 2:1 multiplexers to a buffered, flow-controlled channel merger. It sits in front of shared downstream logic that accepts one word per cycle from several producers.

## Interface
- `WIDTH`, default 8: data bits per channel.
- `NCH`, default 4: number of input channels, ≥2.
- `SELW`, default 2: select/channel-index width; must equal ceil(log2(NCH)).

- `clk` input, 1 bit: rising-edge clock. Single clock domain.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `mode` input, 1 bit: 0 = select mode (`sel` chooses the channel); 1 = round-robin mode.
- `sel` input, SELW bits: channel index, used in select mode only.
- `in_data` input, NCH*WIDTH bits: channel k occupies bits [k*WIDTH +: WIDTH].
- `in_valid` input, NCH bits: per-channel valid.
- `in_ready` output, NCH bits: per-channel ready. Combinational; at most one bit high.
- `out` output, WIDTH bits: registered data.
- `out_valid` output, 1 bit: the output register holds a word.
- `out_ready` input, 1 bit: downstream accepts the word.
- `out_ch` output, SELW bits: index of the channel that supplied `out`.

## Operation
- A transfer occurs on a channel when its valid and ready are both high at a rising edge. The output transfer rule is the same, using `out_valid` and `out_ready`.
- The output stage is one register. `load_en = !out_valid | out_ready`.
- Grant in select mode:
  - Grant channel `sel` when `in_valid[sel]` is high.
  - No grant when `sel ≥ NCH`.
- Grant in round-robin mode:
  - Search from pointer `ptr` upward, modulo NCH.
  - Grant the first channel whose valid is high.
- `in_ready[k] = grant[k] & load_en`. Ungranted channels see ready low.
- On an input transfer from channel k:
  - `out` ← `in_data[k]`, `out_ch` ← k, `out_valid` ← 1.
  - In round-robin mode only, `ptr` ← (k+1) mod NCH. In select mode `ptr` is unchanged.
- On an output transfer with no new grant, `out_valid` ← 0. `out` and `out_ch` keep their values.
- If both transfers occur in the same cycle, the new word replaces the old one with no bubble.
- No grant while `out_valid=1` and `out_ready=0`: hold all state. A producer's valid may stay high indefinitely with no loss.
- Changes to `mode` or `sel` take effect on the next grant decision. They never alter a word already held.
- Reset values:
  - `out`=0, `out_valid`=0, `out_ch`=0, `ptr`=0.
  - `in_ready` is then purely combinational; with `out_valid`=0, `load_en`=1, so `in_ready` follows the grant.

## Timing
- Latency is 1 cycle from an input transfer to `out_valid` and data at the output.
- Throughput is 1 word per cycle when `out_ready` stays high.
- Round-robin fairness: with all NCH channels valid and `out_ready=1`, the grant order is ptr, ptr+1, …, and wraps from NCH-1 to 0. Each channel is served once per NCH cycles.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid`, `mode`, `sel` and `ptr`. No combinational path exists from inputs to `out`, `out_valid` or `out_ch`.
- Reset asserted mid-transfer:
  - The held word is dropped immediately (asynchronous), and `ptr` returns to 0.
  - The first grant after deassertion follows the normal rules.

## Structure
- Shared package `mux_pkg`:
  - `MODE_SEL=1'b0`, `MODE_RR=1'b1`.
  - A clog2 helper function for deriving SELW.
- Sub-module `rr_arbiter`, parameters NCH and SELW:
  - Inputs: request vector, `enable`, `update` strobe, `upd_idx`.
  - Outputs: one-hot grant and its encoded index.
  - Owns the `ptr` register and resets it to 0 asynchronously.
- The top level holds the select-mode decode, the output register and the handshake logic.

## Test plan
- Reset, WIDTH=8, NCH=4:
  - During reset: `out`=0x00, `out_valid`=0, `out_ch`=0.
  - After reset with all inputs idle: `in_ready`=4'b0000.
- Select mode, `sel`=2, `in_valid`=4'b0100, `in_data[2]`=0xA5, `out_ready`=1:
  - Next cycle `out`=0xA5, `out_ch`=2, `out_valid`=1.
  - `in_ready[1]` stays 0 even when `in_valid[1]`=1.
- Round-robin mode, all four channels valid, data k=0x10+k, `out_ready`=1 for 6 cycles:
  - `out_ch` sequence is 0,1,2,3,0,1.
  - `out` sequence is 0x10,0x11,0x12,0x13,0x10,0x11.
- Backpressure, round-robin, channel 1 valid with 0x33:
  - Hold `out_ready`=0 for 3 cycles: `out`=0x33 stays stable, `in_ready`=0, `ptr`=2.
  - Raise `out_ready`: the pending channel 3 word 0x77 loads in the same cycle the 0x33 word is drained.
- Select mode with `sel`=3 on NCH=3 (SELW=2): no grant, `in_ready`=3'b000, `out_valid` stays 0.
- Reset asserted while `out_valid`=1 and `ptr`=3:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, with channels 0 and 2 valid, channel 0 is granted first.
